// File: rtl/wb_dual_retire.sv
// Dual-issue writeback stage. Latches a two-slot retire bundle from MEM,
// aligns/extends load data (including LWL/LWR byte-enabled partial writes),
// and retires the slots serially: slot0 on regfile port 0, then slot1 on
// port 1, with a one-instruction-per-cycle debug trace.
module wb_dual_retire (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,

  input  logic        s0_valid,
  input  logic [31:0] s0_pc,
  input  logic        s0_gr_we,
  input  logic [4:0]  s0_dest,
  input  logic        s0_is_load,
  input  logic [2:0]  s0_ld_op,
  input  logic [1:0]  s0_addr_lo,
  input  logic [31:0] s0_result,
  input  logic [31:0] s0_mem_rdata,

  input  logic        s1_valid,
  input  logic [31:0] s1_pc,
  input  logic        s1_gr_we,
  input  logic [4:0]  s1_dest,
  input  logic        s1_is_load,
  input  logic [2:0]  s1_ld_op,
  input  logic [1:0]  s1_addr_lo,
  input  logic [31:0] s1_result,
  input  logic [31:0] s1_mem_rdata,

  output logic [3:0]  we0,
  output logic [4:0]  waddr0,
  output logic [31:0] wdata0,
  output logic [3:0]  we1,
  output logic [4:0]  waddr1,
  output logic [31:0] wdata1,

  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  typedef enum logic [1:0] {StIdle, StEmit0, StEmit1} state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic        is_load;
    logic [2:0]  ld_op;
    logic [1:0]  addr_lo;
    logic [31:0] result;
    logic [31:0] rdata;
  } slot_t;

  state_e state_q, state_d;
  slot_t  s0_q, s0_d, s1_q, s1_d;
  slot_t  s0_in, s1_in;
  logic   accept;

  logic [3:0]  s0_we, s1_we;
  logic [31:0] s0_wdata, s1_wdata;

  // Byte enables and aligned write data for one held slot: {we, wdata}.
  function automatic logic [35:0] slot_write(input slot_t s);
    logic [3:0]  we;
    logic [31:0] data;
    logic [31:0] sh;
    logic [15:0] half;
    logic [1:0]  lsh;
    sh   = s.rdata >> {s.addr_lo, 3'b000};
    half = s.addr_lo[1] ? s.rdata[31:16] : s.rdata[15:0];
    lsh  = 2'd3 - s.addr_lo;
    we   = 4'hF;
    data = s.result;
    if (s.is_load) begin
      case (s.ld_op)
        3'b001:  data = {{24{sh[7]}}, sh[7:0]};
        3'b010:  data = {24'b0, sh[7:0]};
        3'b011:  data = {{16{half[15]}}, half};
        3'b100:  data = {16'b0, half};
        3'b101: begin
          // LWL fills the high bytes; the regfile keeps the rest.
          we   = 4'hF << lsh;
          data = s.rdata << {lsh, 3'b000};
        end
        3'b110: begin
          // LWR fills the low bytes.
          we   = 4'hF >> s.addr_lo;
          data = s.rdata >> {s.addr_lo, 3'b000};
        end
        default: data = s.rdata;
      endcase
    end
    if (!s.gr_we || s.dest == 5'd0) begin
      we = 4'h0;
    end
    return {we, data};
  endfunction

  // Pack the incoming bundle into slot records.
  always_comb begin
    s0_in = '{valid: s0_valid, pc: s0_pc, gr_we: s0_gr_we, dest: s0_dest,
              is_load: s0_is_load, ld_op: s0_ld_op, addr_lo: s0_addr_lo,
              result: s0_result, rdata: s0_mem_rdata};
    s1_in = '{valid: s1_valid, pc: s1_pc, gr_we: s1_gr_we, dest: s1_dest,
              is_load: s1_is_load, ld_op: s1_ld_op, addr_lo: s1_addr_lo,
              result: s1_result, rdata: s1_mem_rdata};
  end

  // Handshake: a held slot1 still waiting blocks the next bundle in EMIT0.
  always_comb begin
    ws_allowin = (state_q == StIdle) ||
                 (state_q == StEmit0 && !s1_q.valid) ||
                 (state_q == StEmit1);
    accept     = ms_to_ws_valid && ws_allowin && !flush;
  end

  // Next-state and bundle capture.
  always_comb begin
    s0_d    = s0_q;
    s1_d    = s1_q;
    state_d = StIdle;
    if (accept) begin
      s0_d = s0_in;
      s1_d = s1_in;
      if (s0_valid)      state_d = StEmit0;
      else if (s1_valid) state_d = StEmit1;
      else               state_d = StIdle;
    end else if (flush) begin
      // Current emission still happens; a pending slot1 is cancelled.
      state_d = StIdle;
    end else begin
      case (state_q)
        StEmit0: state_d = s1_q.valid ? StEmit1 : StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // State and bundle registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      s0_q    <= '0;
      s1_q    <= '0;
    end else begin
      state_q <= state_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
    end
  end

  // Per-slot write data from the held bundle.
  always_comb begin
    {s0_we, s0_wdata} = slot_write(s0_q);
    {s1_we, s1_wdata} = slot_write(s1_q);
  end

  // Regfile ports and debug trace: only the emitting slot drives anything.
  always_comb begin
    we0               = 4'h0;
    waddr0            = 5'd0;
    wdata0            = 32'd0;
    we1               = 4'h0;
    waddr1            = 5'd0;
    wdata1            = 32'd0;
    debug_wb_pc       = 32'd0;
    debug_wb_rf_wen   = 4'h0;
    debug_wb_rf_wnum  = 5'd0;
    debug_wb_rf_wdata = 32'd0;
    case (state_q)
      StEmit0: begin
        we0               = s0_we;
        waddr0            = s0_q.dest;
        wdata0            = s0_wdata;
        debug_wb_pc       = s0_q.pc;
        debug_wb_rf_wen   = s0_we;
        debug_wb_rf_wnum  = s0_q.dest;
        debug_wb_rf_wdata = s0_wdata;
      end
      StEmit1: begin
        we1               = s1_we;
        waddr1            = s1_q.dest;
        wdata1            = s1_wdata;
        debug_wb_pc       = s1_q.pc;
        debug_wb_rf_wen   = s1_we;
        debug_wb_rf_wnum  = s1_q.dest;
        debug_wb_rf_wdata = s1_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_dual_retire.sv
// Directed bench for wb_dual_retire: inputs driven and outputs sampled on
// the falling edge, expected values hand-computed.
module tb_wb_dual_retire;

  logic        clk = 1'b0;
  logic        reset, flush, ms_to_ws_valid, ws_allowin;
  logic        s0_valid, s0_gr_we, s0_is_load;
  logic [31:0] s0_pc, s0_result, s0_mem_rdata;
  logic [4:0]  s0_dest;
  logic [2:0]  s0_ld_op;
  logic [1:0]  s0_addr_lo;
  logic        s1_valid, s1_gr_we, s1_is_load;
  logic [31:0] s1_pc, s1_result, s1_mem_rdata;
  logic [4:0]  s1_dest;
  logic [2:0]  s1_ld_op;
  logic [1:0]  s1_addr_lo;
  logic [3:0]  we0, we1, debug_wb_rf_wen;
  logic [4:0]  waddr0, waddr1, debug_wb_rf_wnum;
  logic [31:0] wdata0, wdata1, debug_wb_pc, debug_wb_rf_wdata;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] Rd = 32'hAABBCCDD;

  wb_dual_retire dut (
    .clk(clk), .reset(reset), .flush(flush), .ms_to_ws_valid(ms_to_ws_valid),
    .ws_allowin(ws_allowin),
    .s0_valid(s0_valid), .s0_pc(s0_pc), .s0_gr_we(s0_gr_we), .s0_dest(s0_dest),
    .s0_is_load(s0_is_load), .s0_ld_op(s0_ld_op), .s0_addr_lo(s0_addr_lo),
    .s0_result(s0_result), .s0_mem_rdata(s0_mem_rdata),
    .s1_valid(s1_valid), .s1_pc(s1_pc), .s1_gr_we(s1_gr_we), .s1_dest(s1_dest),
    .s1_is_load(s1_is_load), .s1_ld_op(s1_ld_op), .s1_addr_lo(s1_addr_lo),
    .s1_result(s1_result), .s1_mem_rdata(s1_mem_rdata),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    ms_to_ws_valid = 1'b0;
    flush = 1'b0;
    s0_valid = 1'b0; s0_pc = '0; s0_gr_we = 1'b0; s0_dest = '0; s0_is_load = 1'b0;
    s0_ld_op = '0; s0_addr_lo = '0; s0_result = '0; s0_mem_rdata = '0;
    s1_valid = 1'b0; s1_pc = '0; s1_gr_we = 1'b0; s1_dest = '0; s1_is_load = 1'b0;
    s1_ld_op = '0; s1_addr_lo = '0; s1_result = '0; s1_mem_rdata = '0;
  endtask

  task automatic set_s0(input logic [31:0] pc, input logic gr_we, input logic [4:0] dest,
                        input logic ld, input logic [2:0] op, input logic [1:0] a,
                        input logic [31:0] res, input logic [31:0] rdata);
    s0_valid = 1'b1; s0_pc = pc; s0_gr_we = gr_we; s0_dest = dest; s0_is_load = ld;
    s0_ld_op = op; s0_addr_lo = a; s0_result = res; s0_mem_rdata = rdata;
  endtask

  task automatic set_s1(input logic [31:0] pc, input logic gr_we, input logic [4:0] dest,
                        input logic ld, input logic [2:0] op, input logic [1:0] a,
                        input logic [31:0] res, input logic [31:0] rdata);
    s1_valid = 1'b1; s1_pc = pc; s1_gr_we = gr_we; s1_dest = dest; s1_is_load = ld;
    s1_ld_op = op; s1_addr_lo = a; s1_result = res; s1_mem_rdata = rdata;
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Single slot0 load from IDLE; checked one cycle after acceptance.
  task automatic do_load(input string tag, input logic [2:0] op, input logic [1:0] a,
                         input logic [3:0] exp_we, input logic [31:0] exp_d);
    clr_in();
    set_s0(32'h0000_1000, 1'b1, 5'd10, 1'b1, op, a, 32'hDEAD_BEEF, Rd);
    ms_to_ws_valid = 1'b1;
    @(negedge clk);
    check({tag, "_we"}, {28'd0, we0}, {28'd0, exp_we});
    check({tag, "_d"}, wdata0 & be_mask(exp_we), exp_d & be_mask(exp_we));
  endtask

  initial begin
    clr_in();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_allowin", {31'd0, ws_allowin}, 32'd1);
    check("rst_we0", {28'd0, we0}, 32'd0);
    check("rst_we1", {28'd0, we1}, 32'd0);
    check("rst_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
    check("rst_pc", debug_wb_pc, 32'd0);

    // Single ADDU on slot0.
    set_s0(32'h0000_0100, 1'b1, 5'd5, 1'b0, 3'b000, 2'd0, 32'h1234, 32'h0);
    ms_to_ws_valid = 1'b1;
    @(negedge clk);
    clr_in();
    check("addu_we0", {28'd0, we0}, 32'hF);
    check("addu_waddr0", {27'd0, waddr0}, 32'd5);
    check("addu_wdata0", wdata0, 32'h1234);
    check("addu_we1", {28'd0, we1}, 32'd0);
    check("addu_pc", debug_wb_pc, 32'h100);
    check("addu_wnum", {27'd0, debug_wb_rf_wnum}, 32'd5);
    check("addu_dwdata", debug_wb_rf_wdata, 32'h1234);
    @(negedge clk);
    check("addu_idle_we0", {28'd0, we0}, 32'd0);
    check("addu_idle_pc", debug_wb_pc, 32'd0);

    // Dual bundle, same destination.
    set_s0(32'h0000_0200, 1'b1, 5'd3, 1'b0, 3'b000, 2'd0, 32'hAAAA_0001, 32'h0);
    set_s1(32'h0000_0204, 1'b1, 5'd3, 1'b0, 3'b000, 2'd0, 32'hBBBB_0002, 32'h0);
    ms_to_ws_valid = 1'b1;
    @(negedge clk);
    clr_in();
    check("dual_c1_we0", {28'd0, we0}, 32'hF);
    check("dual_c1_wdata0", wdata0, 32'hAAAA_0001);
    check("dual_c1_allowin", {31'd0, ws_allowin}, 32'd0);
    check("dual_c1_we1", {28'd0, we1}, 32'd0);
    check("dual_c1_pc", debug_wb_pc, 32'h200);
    @(negedge clk);
    check("dual_c2_we1", {28'd0, we1}, 32'hF);
    check("dual_c2_waddr1", {27'd0, waddr1}, 32'd3);
    check("dual_c2_wdata1", wdata1, 32'hBBBB_0002);
    check("dual_c2_we0", {28'd0, we0}, 32'd0);
    check("dual_c2_allowin", {31'd0, ws_allowin}, 32'd1);
    check("dual_c2_pc", debug_wb_pc, 32'h204);
    @(negedge clk);
    check("dual_idle_we1", {28'd0, we1}, 32'd0);

    // Load extraction, back-to-back single-slot bundles.
    do_load("lb3",  3'b001, 2'd3, 4'hF, 32'hFFFF_FFAA);
    do_load("lbu3", 3'b010, 2'd3, 4'hF, 32'h0000_00AA);
    do_load("lb1",  3'b001, 2'd1, 4'hF, 32'hFFFF_FFCC);
    do_load("lh2",  3'b011, 2'd2, 4'hF, 32'hFFFF_AABB);
    do_load("lhu0", 3'b100, 2'd0, 4'hF, 32'h0000_CCDD);
    do_load("lw",   3'b000, 2'd0, 4'hF, 32'hAABB_CCDD);
    do_load("lw7",  3'b111, 2'd2, 4'hF, 32'hAABB_CCDD);
    do_load("lwl1", 3'b101, 2'd1, 4'b1100, 32'hCCDD_0000);
    do_load("lwl3", 3'b101, 2'd3, 4'b1111, 32'hAABB_CCDD);
    do_load("lwr2", 3'b110, 2'd2, 4'b0011, 32'h0000_AABB);
    do_load("lwr0", 3'b110, 2'd0, 4'b1111, 32'hAABB_CCDD);
    clr_in();
    @(negedge clk);

    // Destination r0 suppresses the write, trace keeps the PC.
    set_s0(32'h0000_0300, 1'b1, 5'd0, 1'b0, 3'b000, 2'd0, 32'h55, 32'h0);
    ms_to_ws_valid = 1'b1;
    @(negedge clk);
    clr_in();
    check("r0_we0", {28'd0, we0}, 32'd0);
    check("r0_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
    check("r0_pc", debug_wb_pc, 32'h300);

    // Slot0 empty: slot1 (LWR a=1) goes straight to port 1.
    set_s1(32'h0000_0404, 1'b1, 5'd12, 1'b1, 3'b110, 2'd1, 32'h0, Rd);
    ms_to_ws_valid = 1'b1;
    @(negedge clk);
    clr_in();
    check("s1only_we1", {28'd0, we1}, 32'b0111);
    check("s1only_d", wdata1 & 32'h00FF_FFFF, 32'h00AA_BBCC);
    check("s1only_we0", {28'd0, we0}, 32'd0);
    check("s1only_pc", debug_wb_pc, 32'h404);
    check("s1only_wnum", {27'd0, debug_wb_rf_wnum}, 32'd12);
    @(negedge clk);
    check("s1only_idle", {28'd0, we1}, 32'd0);

    // Flush in IDLE blocks an otherwise acceptable bundle.
    set_s0(32'h0000_0500, 1'b1, 5'd9, 1'b0, 3'b000, 2'd0, 32'h99, 32'h0);
    ms_to_ws_valid = 1'b1;
    flush = 1'b1;
    check("fl_idle_allowin", {31'd0, ws_allowin}, 32'd1);
    @(negedge clk);
    clr_in();
    check("fl_idle_we0", {28'd0, we0}, 32'd0);
    check("fl_idle_pc", debug_wb_pc, 32'd0);

    // Flush in EMIT0 with slot1 held: slot0 written, slot1 cancelled.
    set_s0(32'h0000_0600, 1'b1, 5'd7, 1'b0, 3'b000, 2'd0, 32'h7777, 32'h0);
    set_s1(32'h0000_0604, 1'b1, 5'd8, 1'b0, 3'b000, 2'd0, 32'h8888, 32'h0);
    ms_to_ws_valid = 1'b1;
    @(negedge clk);
    clr_in();
    set_s0(32'h0000_0700, 1'b1, 5'd11, 1'b0, 3'b000, 2'd0, 32'hABCD, 32'h0);
    ms_to_ws_valid = 1'b1;
    flush = 1'b1;
    check("fl_e0_we0", {28'd0, we0}, 32'hF);
    check("fl_e0_wdata0", wdata0, 32'h7777);
    check("fl_e0_pc", debug_wb_pc, 32'h600);
    @(negedge clk);
    clr_in();
    check("fl_e0_after_we1", {28'd0, we1}, 32'd0);
    check("fl_e0_after_we0", {28'd0, we0}, 32'd0);
    check("fl_e0_after_pc", debug_wb_pc, 32'd0);
    check("fl_e0_after_allowin", {31'd0, ws_allowin}, 32'd1);

    // Next bundle after the flush is accepted normally.
    set_s0(32'h0000_0800, 1'b1, 5'd13, 1'b0, 3'b000, 2'd0, 32'h1313, 32'h0);
    ms_to_ws_valid = 1'b1;
    @(negedge clk);
    clr_in();
    check("post_fl_we0", {28'd0, we0}, 32'hF);
    check("post_fl_wdata0", wdata0, 32'h1313);
    check("post_fl_pc", debug_wb_pc, 32'h800);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_dual_retire.md
Name: wb_dual_retire

Overview:
Dual-issue writeback stage; the producer side of the 2-write-port, byte-enabled register file. Latches one retire bundle (slot0 = older, slot1 = younger) from MEM and performs load-data extraction and alignment, including LWL/LWR partial writes via byte enables. Drives the regfile write ports and a one-instruction-per-cycle debug trace, so a dual bundle retires serially over two cycles.

Parameters:
none (fixed 2 slots, 32-bit datapath)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  pipeline flush from CP0 (exception/ERET)
ms_to_ws_valid  in  1  MEM presents a bundle
ws_allowin  out  1  WB accepts a bundle this cycle
sN_valid  in  1  slot N (N=0,1) holds a real instruction
sN_pc  in  32  slot N PC
sN_gr_we  in  1  slot N writes a GPR
sN_dest  in  5  slot N destination
sN_is_load  in  1  slot N is a load
sN_ld_op  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LWL, 110 LWR, 111 = LW
sN_addr_lo  in  2  load address [1:0]
sN_result  in  32  ALU/move result (non-load)
sN_mem_rdata  in  32  raw word from data memory (load)
we0  out  4  regfile port 0 byte enables (slot0 only)
waddr0  out  5  port 0 address
wdata0  out  32  port 0 data
we1  out  4  regfile port 1 byte enables (slot1 only)
waddr1  out  5  port 1 address
wdata1  out  32  port 1 data
debug_wb_pc  out  32  PC of the instruction retiring this cycle
debug_wb_rf_wen  out  4  its byte enables
debug_wb_rf_wnum  out  5  its dest
debug_wb_rf_wdata  out  32  its write data

Behaviour:
- State: IDLE, EMIT0, EMIT1. Bundle registers hold both slots. Outputs are combinational from state and bundle registers.
- ws_allowin = (IDLE) | (EMIT0 & !held_s1_valid) | (EMIT1). Accept = ms_to_ws_valid & ws_allowin & !flush.
- On accept, next state = EMIT0 if s0_valid, else EMIT1 if s1_valid, else IDLE. Bundle is captured.
- No accept: EMIT0 -> EMIT1 if held_s1_valid, else IDLE. EMIT1 -> IDLE.
- Latency: bundle accepted at edge T; slot0 writes in cycle T+1; slot1 writes in T+1 (slot0 absent) or T+2. Back-to-back single-slot bundles sustain 1/cycle; dual bundles sustain 2 cycles each.
- EMIT0 drives port 0 only (we1=0). EMIT1 drives port 1 only (we0=0). IDLE: we0=we1=0. The two ports are never both non-zero, so same-dest ordering is resolved by time (slot1 lands last).
- Write enable per slot: we=0 if !gr_we or dest==0. Otherwise:
  - Non-load: we=4'hF, wdata=result.
  - LW: 4'hF, rdata.
  - LB/LBU: byte rdata[8a+7:8a] (a=addr_lo), sign- or zero-extended, 4'hF.
  - LH/LHU: a[1] ? rdata[31:16] : rdata[15:0], extended, 4'hF. a[0] is ignored (misalignment is trapped upstream).
  - LWL: we = 4'hF << (3-a), wdata = rdata << 8*(3-a).
  - LWR: we = 4'hF >> a, wdata = rdata >> 8*a.
  - Unenabled bytes are don't-care; the regfile merges old contents.
- waddrN = held dest. wdataN/waddrN are don't-care when weN=0.
- Debug trace: in EMIT0 it mirrors slot0; in EMIT1 it mirrors slot1. pc is reported even when wen=0. In IDLE: pc=0, wen=0, wnum=0, wdata=0.
- Flush: the current-cycle emission still occurs. Next state is forced to IDLE, which cancels a pending slot1. The bundle offered in the flush cycle is not accepted. ws_allowin is unaffected by flush.
- Reset: state=IDLE, bundle registers cleared. All outputs are 0 except ws_allowin=1.
- reset has priority over flush and accept.

Test Plan:
- Reset asserted 2 cycles, then released -> we0=we1=0, debug_wb_rf_wen=0, ws_allowin=1.
- Single slot0 ADDU (dest 5, result 32'h1234) -> next cycle we0=4'hF, waddr0=5, wdata0=32'h1234, we1=0, debug_wb_pc=s0_pc; IDLE after.
- Dual bundle, both dest 3 (results A, B) -> cycle1: we0=F/wdata0=A, ws_allowin=0, we1=0; cycle2: we1=F/wdata1=B, ws_allowin=1. Trace shows pc0 then pc1.
- Loads with rdata=32'hAABBCCDD:
  - LB a=3 -> FFFFFFAA; LBU a=3 -> 000000AA; LH a=2 -> FFFFAABB.
  - LWL a=1 -> we=4'b1100, wdata[31:16]=CCDD.
  - LWR a=2 -> we=4'b0011, wdata[15:0]=AABB.
- s0 gr_we=1 dest=0 -> we0=0, debug wen=0, debug pc=s0_pc. s0_valid=0 with s1 valid -> slot1 emitted on port 1 in T+1.
- flush while in EMIT0 with slot1 held -> slot0 still written, slot1 never written, state IDLE. Bundle offered in that cycle is dropped; the next bundle is accepted normally.
